screen_raster_scanner: RTL
==========================

SCREEN_RASTER_SCANNER -- requirements
Module: screen_raster_scanner

Interface
REQ-001 Parameter H_RES, default 160, pixels per row.
REQ-002 Parameter V_RES, default 120, rows per frame.
REQ-003 Parameter COORD_W, default 8, width of x/y coordinates and row inputs.
REQ-004 Parameter ADDR_W, default 15, image-memory address width.
REQ-005 Parameter READ_LATENCY, default 1, range 1-4, image-memory read latency in accepted cycles.
REQ-006 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  sole clock, all state on rising edge.
REQ-008 reset  input  1  synchronous active-high reset.
REQ-009 start  input  1  request one scan; sampled only in IDLE.
REQ-010 abort  input  1  cancel scan in progress.
REQ-011 first_row  input  COORD_W  first row scanned; latched at start.
REQ-012 last_row  input  COORD_W  last row scanned; latched at start.
REQ-013 base_addr  input  ADDR_W  address of pixel (0, first_row); latched at start.
REQ-014 pixel_ready  input  1  downstream accepts; 0 stalls the whole pipeline.
REQ-015 busy  output  1  scan in progress (SCAN, DRAIN, DONE).
REQ-016 done  output  1  one-cycle pulse at scan completion.
REQ-017 addr, addr_valid  output  ADDR_W, 1  image-memory read address and its qualifier.
REQ-018 draw_x, draw_y, draw_valid  output  COORD_W, COORD_W, 1  coordinate aligned with memory read data; plot strobe.

Function
REQ-019 FSM states SHALL be IDLE, SCAN, DRAIN, DONE.
REQ-020 IDLE + start=1: latch first_row, base_addr and min(last_row, V_RES-1); enter SCAN, or DONE if first_row > clamped last_row (zero pixels).
REQ-021 SCAN: each cycle with pixel_ready=1 issues one pixel: addr_valid=1, addr = base + (y-first_row)*H_RES + x, computed by increment, never a multiplier.
REQ-022 Order SHALL be x 0..H_RES-1, then x=0, y+1; addr increments by 1 per accepted pixel, wrapping modulo 2^ADDR_W.
REQ-023 First issued pixel SHALL appear in the cycle after start is sampled: x=0, y=first_row, addr=base_addr.
REQ-024 pixel_ready=0 SHALL hold addr, counters, delay line and all outputs; addr_valid and draw_valid SHALL be forced to 0 during the stall.
REQ-025 draw_x/draw_y/draw_valid SHALL equal the issued x/y/valid delayed by exactly READ_LATENCY accepted cycles.
REQ-026 After issuing (H_RES-1, last_row): enter DRAIN for READ_LATENCY accepted cycles, then DONE.
REQ-027 DONE lasts one cycle with done=1, busy=1; next state IDLE; start in DONE is ignored.
REQ-028 abort=1 in SCAN/DRAIN/DONE: next cycle IDLE, delay line cleared, no done pulse; abort takes priority over pixel_ready.
REQ-029 Counters SHALL never exceed H_RES-1 / V_RES-1; no out-of-range coordinate is ever issued.

Reset
REQ-030 reset=1 SHALL, at the next edge, force IDLE, busy=0, done=0, addr=0, addr_valid=0, draw_x=0, draw_y=0, draw_valid=0 and clear the delay line, overriding start and abort.
REQ-031 Reset mid-scan SHALL abandon the scan without a done pulse; the first start after reset is deasserted begins a clean scan.

Verification
REQ-032 Defaults, start cycle 0, first_row=0, last_row=119, base=0, pixel_ready=1 -> addr_valid cycles 1-19200, addr 0..19199, draw_valid cycles 2-19201, done only in cycle 19202.
REQ-033 first_row=0, last_row=28, base=0 -> 4640 pixels; last addr 4639 at (159,28); single done pulse.
REQ-034 pixel_ready low for 5 cycles mid-row at x=37 -> addr/x frozen at x=37, valids 0, no pixel skipped or duplicated; done delayed by 5 cycles.
REQ-035 first_row=92, last_row=200, base=32700 -> last_row clamped to 119; first addr 32700, addr wraps 32767->0; 4480 pixels total.
REQ-036 abort at pixel 500; separately reset at pixel 500 -> IDLE next cycle, no done; a following start scans from (0, first_row).
REQ-037 first_row=50, last_row=40 -> no addr_valid, busy and done high for exactly one cycle (cycle 1).

Source files
------------

// File: rtl/screen_raster_scanner.sv
// screen_raster_scanner: raster-order image-memory address generator with latency-matched plot coordinates
module screen_raster_scanner #(
    parameter int H_RES        = 160,
    parameter int V_RES        = 120,
    parameter int COORD_W      = 8,
    parameter int ADDR_W       = 15,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] first_row,
    input  logic [COORD_W-1:0] last_row,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               pixel_ready,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  addr,
    output logic               addr_valid,
    output logic [COORD_W-1:0] draw_x,
    output logic [COORD_W-1:0] draw_y,
    output logic               draw_valid
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(V_RES - 1);
    localparam logic [2:0]         L_LAST = 3'(READ_LATENCY - 1);
    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, last_q, last_d, clamp;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [COORD_W-1:0] dx_q [READ_LATENCY];
    logic [COORD_W-1:0] dx_d [READ_LATENCY];
    logic [COORD_W-1:0] dy_q [READ_LATENCY];
    logic [COORD_W-1:0] dy_d [READ_LATENCY];
    logic               dv_q [READ_LATENCY];
    logic               dv_d [READ_LATENCY];
    logic               kill, step, scan;
    assign kill = abort && state_q != IDLE;
    assign step = pixel_ready && !kill;
    assign scan = state_q == SCAN;
    assign clamp = (last_row > Y_MAX) ? Y_MAX : last_row;
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        last_d  = last_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        dv_d    = dv_q;
        if (step) begin
            dx_d[0] = scan ? x_q : '0;
            dy_d[0] = scan ? y_q : '0;
            dv_d[0] = scan;
            for (int i = 1; i < READ_LATENCY; i++) begin
                dx_d[i] = dx_q[i-1];
                dy_d[i] = dy_q[i-1];
                dv_d[i] = dv_q[i-1];
            end
        end
        case (state_q)
            IDLE: if (start) begin
                x_d     = '0;
                y_d     = first_row;
                last_d  = clamp;
                addr_d  = base_addr;
                state_d = (first_row > clamp) ? DONE : SCAN;
            end
            SCAN: if (step) begin
                addr_d = addr_q + 1'b1;
                if (x_q != X_MAX) begin
                    x_d = x_q + 1'b1;
                end else if (y_q != last_q) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                end else begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: if (step) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == L_LAST) ? DONE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
            dx_d    = '{default: '0};
            dy_d    = '{default: '0};
            dv_d    = '{default: 1'b0};
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            dx_q    <= '{default: '0};
            dy_q    <= '{default: '0};
            dv_q    <= '{default: 1'b0};
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            dv_q    <= dv_d;
        end
    end
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE && !abort;
    assign addr       = addr_q;
    assign addr_valid = scan && step;
    assign draw_x     = dx_q[READ_LATENCY-1];
    assign draw_y     = dy_q[READ_LATENCY-1];
    assign draw_valid = dv_q[READ_LATENCY-1] && step;
endmodule
